// File: rtl/node_mac.sv
// node_mac: per-neuron multiply-accumulate stage fed by input_node_timer.
// Accumulates in_data*weight onto a bias-preloaded accumulator, one term per
// cycle while the timer sweeps. At the end of the sweep it applies ReLU with
// saturation and offers the result on a valid/ready handshake.
//
// Ports:
//   clk, n_rst          clock (rising edge), synchronous active-low reset
//   coef_ready          high for the whole node computation (timer enable)
//   input_num           timer index of the current term
//   n_start_done        timer rollover flag, marks the final term
//   in_data, weight     signed Q(FRAC_W) operands for the current term
//   bias                signed Q(FRAC_W) node bias, stable during a run
//   out_ready           downstream accepts node_out
//   node_out            registered activated result
//   node_valid          node_out holds an unconsumed result
//   term_cnt            products accumulated in the current/last run
//   idx_err             sticky index-sequence error for the current run
//   busy                high whenever not IDLE
module node_mac #(
   parameter int DATA_W = 8,
   parameter int FRAC_W = 4,
   parameter int IDX_W  = 7,
   parameter int ACC_W  = 24
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     coef_ready,
   input  logic [IDX_W-1:0]         input_num,
   input  logic                     n_start_done,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic signed [DATA_W-1:0] weight,
   input  logic signed [DATA_W-1:0] bias,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        node_out,
   output logic                     node_valid,
   output logic [IDX_W:0]           term_cnt,
   output logic                     idx_err,
   output logic                     busy
);

   typedef enum logic [2:0] {IDLE, ACCUM, ACT, OUTPUT, WAIT_CLR} state_t;

   localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);

   state_t state, state_nxt;

   logic signed [ACC_W-1:0]    acc;
   logic [IDX_W-1:0]           exp_idx;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    bias_ext;
   logic signed [ACC_W-1:0]    acc_sum;
   logic signed [ACC_W-1:0]    shifted;
   logic [IDX_W-1:0]           exp_cur;
   logic                       idx_mis;
   logic [DATA_W-1:0]          act_val;

   assign prod     = in_data * weight;
   assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign bias_ext = {{(ACC_W - DATA_W - FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};

   // The first term is summed straight onto the bias so no cycle is lost
   // loading the accumulator.
   assign acc_sum  = ((state == IDLE) ? bias_ext : acc) + prod_ext;

   // exp_idx may hold a stale value for a cycle after returning to IDLE,
   // so the first-term check compares against zero directly.
   assign exp_cur  = (state == IDLE) ? '0 : exp_idx;
   assign idx_mis  = (input_num != exp_cur);

   assign shifted  = acc >>> FRAC_W;
   assign busy     = (state != IDLE);

   always_comb begin
      act_val = shifted[DATA_W-1:0];
      if (shifted[ACC_W-1]) begin
         act_val = '0;
      end else if (shifted > OUT_MAX) begin
         act_val = OUT_MAX[DATA_W-1:0];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (coef_ready) state_nxt = n_start_done ? ACT : ACCUM;
         ACCUM:    if (!coef_ready) state_nxt = IDLE;
                   else if (n_start_done) state_nxt = ACT;
         ACT:      state_nxt = OUTPUT;
         OUTPUT:   if (out_ready) state_nxt = coef_ready ? WAIT_CLR : IDLE;
         WAIT_CLR: if (!coef_ready) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         acc        <= '0;
         exp_idx    <= '0;
         term_cnt   <= '0;
         idx_err    <= 1'b0;
         node_out   <= '0;
         node_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (coef_ready) begin
                  acc      <= acc_sum;
                  term_cnt <= (IDX_W+1)'(1);
                  exp_idx  <= IDX_W'(1);
                  idx_err  <= idx_mis;
               end else begin
                  acc     <= bias_ext;
                  exp_idx <= '0;
                  idx_err <= 1'b0;
               end
            end
            ACCUM: begin
               if (coef_ready) begin
                  acc      <= acc_sum;
                  term_cnt <= term_cnt + (IDX_W+1)'(1);
                  exp_idx  <= exp_idx + IDX_W'(1);
                  if (idx_mis) idx_err <= 1'b1;
               end
            end
            ACT: begin
               node_out   <= act_val;
               node_valid <= 1'b1;
            end
            OUTPUT: begin
               if (out_ready) node_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_node_mac.sv
// tb_node_mac: table-driven check of node_mac. Each record describes one
// node run (operands, index skip, backpressure length, coef_ready drop during
// OUTPUT) and the hand-computed result; abort and mid-run reset are
// separate hand-written sequences.
module tb_node_mac;

   logic              clk = 1'b0;
   logic              n_rst;
   logic              coef_ready;
   logic [6:0]        input_num;
   logic              n_start_done;
   logic signed [7:0] in_data;
   logic signed [7:0] weight;
   logic signed [7:0] bias;
   logic              out_ready;
   logic [7:0]        node_out;
   logic              node_valid;
   logic [7:0]        term_cnt;
   logic              idx_err;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   node_mac #(.DATA_W(8), .FRAC_W(4), .IDX_W(7), .ACC_W(24)) dut (
      .clk(clk), .n_rst(n_rst), .coef_ready(coef_ready), .input_num(input_num),
      .n_start_done(n_start_done), .in_data(in_data), .weight(weight),
      .bias(bias), .out_ready(out_ready), .node_out(node_out),
      .node_valid(node_valid), .term_cnt(term_cnt), .idx_err(idx_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                nterms;
      int                skip;     // index value skipped from here on, -1 none
      logic signed [7:0] din[4];   // cycled every 4 terms
      logic signed [7:0] wt[4];
      logic signed [7:0] b;
      int                hold;     // cycles of out_ready=0 after node_valid
      bit                drop;     // drop coef_ready while in OUTPUT
      logic [7:0]        exp_out;
      logic [7:0]        exp_cnt;
      bit                exp_err;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input vec_t v, input int i);
      return (v.skip >= 0 && i >= v.skip) ? i + 1 : i;
   endfunction

   task automatic run_vec(input vec_t v, input int id);
      out_ready  = (v.hold == 0);
      coef_ready = 1'b1;
      bias       = v.b;
      for (int i = 0; i < v.nterms; i++) begin
         input_num    = 7'(idx_of(v, i));
         in_data      = v.din[i % 4];
         weight       = v.wt[i % 4];
         n_start_done = (i == v.nterms - 1);
         @(negedge clk);
         chk($sformatf("v%0d idx_err t%0d", id, i), 32'(idx_err),
             32'(v.skip >= 0 && i >= v.skip));
         if (i == 0) chk($sformatf("v%0d busy", id), 32'(busy), 32'd1);
      end
      // Timer sits at rollover; operands now garbage and must be ignored.
      in_data = 8'sd127;
      weight  = 8'sd127;
      chk($sformatf("v%0d valid in ACT", id), 32'(node_valid), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d valid", id), 32'(node_valid), 32'd1);
      chk($sformatf("v%0d node_out", id), 32'(node_out), 32'(v.exp_out));
      chk($sformatf("v%0d term_cnt", id), 32'(term_cnt), 32'(v.exp_cnt));
      chk($sformatf("v%0d idx_err", id), 32'(idx_err), 32'(v.exp_err));
      if (v.drop) coef_ready = 1'b0;
      for (int k = 0; k < v.hold; k++) begin
         @(negedge clk);
         chk($sformatf("v%0d hold valid c%0d", id, k), 32'(node_valid), 32'd1);
         chk($sformatf("v%0d hold out c%0d", id, k), 32'(node_out), 32'(v.exp_out));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d valid after xfer", id), 32'(node_valid), 32'd0);
      chk($sformatf("v%0d busy after xfer", id), 32'(busy), 32'(!v.drop));
      if (!v.drop) begin
         repeat (2) @(negedge clk);
         chk($sformatf("v%0d wait_clr busy", id), 32'(busy), 32'd1);
         chk($sformatf("v%0d wait_clr valid", id), 32'(node_valid), 32'd0);
         coef_ready = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d idle busy", id), 32'(busy), 32'd0);
      end
      n_start_done = 1'b0;
      input_num    = '0;
      @(negedge clk);
      chk($sformatf("v%0d idle err clr", id), 32'(idx_err), 32'd0);
      chk($sformatf("v%0d idle out held", id), 32'(node_out), 32'(v.exp_out));
      chk($sformatf("v%0d idle cnt held", id), 32'(term_cnt), 32'(v.exp_cnt));
   endtask

   initial begin
      // basic sum: (1+2-1) = 2.0 -> 32
      vecs[0] = '{nterms:3, skip:-1, din:'{8'sd16, 8'sd32, -8'sd16, 8'sd0},
                  wt:'{8'sd16, 8'sd16, 8'sd16, 8'sd16}, b:8'sd0, hold:0, drop:0,
                  exp_out:8'd32, exp_cnt:8'd3, exp_err:0};
      // ReLU clamp: -512-256+128 = -640 -> -40 -> 0
      vecs[1] = '{nterms:2, skip:-1, din:'{-8'sd32, -8'sd16, 8'sd0, 8'sd0},
                  wt:'{8'sd16, 8'sd16, 8'sd16, 8'sd16}, b:8'sd8, hold:0, drop:0,
                  exp_out:8'd0, exp_cnt:8'd2, exp_err:0};
      // saturation: 128*16129 + 2032 -> far above 127
      vecs[2] = '{nterms:128, skip:-1, din:'{8'sd127, 8'sd127, 8'sd127, 8'sd127},
                  wt:'{8'sd127, 8'sd127, 8'sd127, 8'sd127}, b:8'sd127, hold:0, drop:0,
                  exp_out:8'd127, exp_cnt:8'd128, exp_err:0};
      // single term (max_input=0) with backpressure: 1536-64 = 1472 -> 92
      vecs[3] = '{nterms:1, skip:-1, din:'{8'sd48, 8'sd0, 8'sd0, 8'sd0},
                  wt:'{8'sd32, 8'sd0, 8'sd0, 8'sd0}, b:-8'sd4, hold:5, drop:0,
                  exp_out:8'd92, exp_cnt:8'd1, exp_err:0};
      // index sequence 0,1,3,4; coef_ready dropped in OUTPUT: 4*256 -> 64
      vecs[4] = '{nterms:4, skip:2, din:'{8'sd16, 8'sd16, 8'sd16, 8'sd16},
                  wt:'{8'sd16, 8'sd16, 8'sd16, 8'sd16}, b:8'sd0, hold:2, drop:1,
                  exp_out:8'd64, exp_cnt:8'd4, exp_err:1};
      // fractional truncation: 400-15 = 385 -> 24.0625 -> 24
      vecs[5] = '{nterms:2, skip:-1, din:'{8'sd20, -8'sd3, 8'sd0, 8'sd0},
                  wt:'{8'sd20, 8'sd5, 8'sd0, 8'sd0}, b:8'sd0, hold:0, drop:0,
                  exp_out:8'd24, exp_cnt:8'd2, exp_err:0};
      // full run after abort: 10*128 - 256 = 1024 -> 64
      vecs[6] = '{nterms:10, skip:-1, din:'{8'sd16, 8'sd16, 8'sd16, 8'sd16},
                  wt:'{8'sd8, 8'sd8, 8'sd8, 8'sd8}, b:-8'sd16, hold:0, drop:0,
                  exp_out:8'd64, exp_cnt:8'd10, exp_err:0};

      n_rst = 1'b0; coef_ready = 1'b0; input_num = '0; n_start_done = 1'b0;
      in_data = '0; weight = '0; bias = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst node_out", 32'(node_out), 32'd0);
      chk("rst node_valid", 32'(node_valid), 32'd0);
      chk("rst term_cnt", 32'(term_cnt), 32'd0);
      chk("rst idx_err", 32'(idx_err), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      n_rst = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

      // abort: 3 of 10 terms, then coef_ready drops
      coef_ready = 1'b1; bias = -8'sd16;
      for (int i = 0; i < 3; i++) begin
         input_num = 7'(i); in_data = 8'sd16; weight = 8'sd8;
         @(negedge clk);
      end
      coef_ready = 1'b0;
      @(negedge clk);
      chk("abort busy", 32'(busy), 32'd0);
      repeat (3) begin
         @(negedge clk);
         chk("abort no valid", 32'(node_valid), 32'd0);
      end
      chk("abort out held", 32'(node_out), 32'd24);
      run_vec(vecs[6], 6);

      // reset mid-run, with a bad first index so idx_err is set beforehand
      coef_ready = 1'b1; bias = 8'sd10;
      for (int i = 0; i < 3; i++) begin
         input_num = 7'(i + 1); in_data = 8'sd16; weight = 8'sd16;
         @(negedge clk);
      end
      chk("pre-rst idx_err", 32'(idx_err), 32'd1);
      chk("pre-rst term_cnt", 32'(term_cnt), 32'd3);
      n_rst = 1'b0;
      @(negedge clk);
      chk("mid-rst node_out", 32'(node_out), 32'd0);
      chk("mid-rst term_cnt", 32'(term_cnt), 32'd0);
      chk("mid-rst idx_err", 32'(idx_err), 32'd0);
      chk("mid-rst busy", 32'(busy), 32'd0);
      chk("mid-rst valid", 32'(node_valid), 32'd0);
      n_rst = 1'b1; coef_ready = 1'b0; input_num = '0;
      repeat (2) @(negedge clk);
      chk("post-rst busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
